// File: rtl/mux_uart_tx.sv
// mux_uart_tx: memory-mapped UART transmitter on the CPU6 bus with a small
// transmit FIFO and an 8N1 serializer.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit time (2..255)
//   DEPTH         transmit FIFO depth in bytes (power of two, 2..16)
//   BASE          status register address; data register lives at BASE+1
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   address    in   [15:0] bus address
//   write_en   in   bus write strobe
//   data_in    in   [7:0] bus write data
//   data_out   out  [7:0] read data, combinational from address and state
//   sel        out  high when address hits BASE or BASE+1
//   txd        out  serial transmit line, idle high, registered
//   tx_active  out  high while a frame is being shifted out
module mux_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4,
  parameter logic [15:0] BASE         = 16'hf200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        sel,
  output logic        txd,
  output logic        tx_active
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [15:0]       DATA_ADDR  = BASE + 16'd1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(7);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // State and datapath registers
  logic [1:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic              r_overrun;
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Next-state values and strobes
  logic [1:0]        w_nxt_state;
  logic [BAUD_W-1:0] w_nxt_baud;
  logic [BIT_W-1:0]  w_nxt_bit;
  logic [7:0]        w_nxt_shift;
  logic              w_nxt_txd;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_data_wr;
  logic              w_push;
  logic              w_drop;
  logic              w_ovr_clr;
  logic              w_baud_end;

  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // never rescues a push into a full FIFO.
  assign w_full     = (r_count == COUNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_data_wr  = write_en && (address == DATA_ADDR);
  assign w_push     = w_data_wr && !w_full;
  assign w_drop     = w_data_wr && w_full;
  assign w_ovr_clr  = write_en && (address == BASE);
  assign w_baud_end = (r_baud == BAUD_LAST);

  // Serializer next-state and output logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_baud  = r_baud;
    w_nxt_bit   = r_bit;
    w_nxt_shift = r_shift;
    w_nxt_txd   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_txd = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_shift = r_mem[r_rd_ptr];
          w_nxt_bit   = '0;
          w_nxt_baud  = '0;
          w_nxt_txd   = 1'b0;
          w_nxt_state = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_nxt_baud  = '0;
          w_nxt_bit   = '0;
          w_nxt_txd   = r_shift[0];
          w_nxt_state = S_DATA;
        end else begin
          w_nxt_baud = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_nxt_baud = '0;
          if (r_bit == BIT_LAST) begin
            w_nxt_txd   = 1'b1;
            w_nxt_state = S_STOP;
          end else begin
            // Shift right; the next bit to present is the current bit 1
            w_nxt_bit   = r_bit + BIT_W'(1);
            w_nxt_shift = {1'b0, r_shift[7:1]};
            w_nxt_txd   = r_shift[1];
          end
        end else begin
          w_nxt_baud = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_nxt_baud = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit with no idle gap
            w_pop       = 1'b1;
            w_nxt_shift = r_mem[r_rd_ptr];
            w_nxt_bit   = '0;
            w_nxt_txd   = 1'b0;
            w_nxt_state = S_START;
          end else begin
            w_nxt_txd   = 1'b1;
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_baud = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_nxt_txd   = 1'b1;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State register, FIFO pointers/count and overrun flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_overrun <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_baud  <= w_nxt_baud;
      r_bit   <= w_nxt_bit;
      r_shift <= w_nxt_shift;
      r_txd   <= w_nxt_txd;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care while pointers sit in reset
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  assign txd       = r_txd;
  assign tx_active = (r_state != S_IDLE);

  // Bus read mux
  always_comb begin
    data_out = 8'h00;
    sel      = 1'b0;
    if (address == BASE) begin
      sel      = 1'b1;
      data_out = {tx_active, r_overrun, 4'b0000, ~w_full, 1'b0};
    end else if (address == DATA_ADDR) begin
      sel = 1'b1;
    end
  end

endmodule

// File: doc/mux_uart_tx.md
MUX_UART_TX -- requirements
Module: mux_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clocks per serial bit time (legal range 2..255).
REQ-002 Parameter DEPTH, default 4, transmit FIFO depth in bytes (power of two, 2..16).
REQ-003 Parameter BASE, default 16'hf200, status register address; the data register is at BASE+1.
REQ-004 clock  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  16  CPU6 bus address.
REQ-007 write_en  input  1  CPU6 bus write strobe, sampled on the rising clock edge.
REQ-008 data_in  input  8  CPU6 write data (CPU-to-memory bus).
REQ-009 data_out  output  8  read data, combinational from address and internal state.
REQ-010 sel  output  1  high when address is BASE or BASE+1, so the top-level read mux selects data_out.
REQ-011 txd  output  1  serial transmit line; idle high.
REQ-012 tx_active  output  1  high while a frame is being shifted out.

Function
REQ-013 Status read at BASE: data_out = {tx_active, overrun, 4'b0, ~full, 1'b0}; an idle, empty block reads 8'h02.
REQ-014 Read at BASE+1 returns 8'h00; no receiver exists.
REQ-015 Any other address returns data_out = 8'h00 and sel = 0.
REQ-016 write_en with address BASE+1 pushes data_in unmodified, all 8 bits, when the FIFO is not full before the edge.
REQ-017 A push while full is dropped and sets the sticky overrun bit; FIFO contents are unchanged.
REQ-018 Fullness is evaluated before the edge: a push into a full FIFO is dropped even if a pop occurs on the same edge.
REQ-019 Push and pop on the same edge with a non-full, non-empty FIFO leave count unchanged and preserve order.
REQ-020 write_en with address BASE clears overrun; the data value is ignored.
REQ-021 Pointers wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH).
REQ-022 FSM states: IDLE, START, DATA, STOP.
REQ-023 IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, and go to START.
REQ-024 START: txd=0 for CLKS_PER_BIT clocks, then DATA.
REQ-025 DATA: 8 bits, LSB first, each bit for CLKS_PER_BIT clocks, then STOP.
REQ-026 STOP: txd=1 for CLKS_PER_BIT clocks. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
REQ-027 Frame length is exactly 10*CLKS_PER_BIT clocks (8N1).
REQ-028 Latency: a write accepted at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1; txd is low from edge N+1.
REQ-029 tx_active = (state != IDLE).
REQ-030 txd is driven from a register and is glitch-free.

Reset
REQ-031 With reset high at a rising edge: state=IDLE, txd=1, tx_active=0, FIFO empty with pointers 0, overrun=0, baud and bit counters 0.
REQ-032 Reset mid-frame aborts the frame immediately (txd=1 from the next edge) and discards all queued bytes.
REQ-033 Bus writes during reset are ignored.
REQ-034 After reset, a status read returns 8'h02.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-035 Reset, then read F200 -> data_out=8'h02, sel=1, txd=1; read F202 -> sel=0, data_out=8'h00.
REQ-036 Write 8'h48 to F201 -> txd low from the next edge; sampled txd over 40 clocks decodes 0,0,0,0,1,0,0,1,0,1 (start, LSB-first data, stop).
REQ-037 Write 8'h68, 8'h65, 8'h6c, 8'h6c on consecutive cycles -> no overrun; 160 contiguous clocks of frames with no idle gap; decoded bytes in order.
REQ-038 Write 6 bytes back-to-back while idle -> first 5 accepted (1 popped plus 4 queued), 6th dropped; status reads 8'hc0 (active, overrun, full); write F200 -> overrun clears, status 8'h80.
REQ-039 Reset asserted at clock 15 of a frame with 2 bytes queued -> txd=1 and status 8'h02 after the edge; no further frames transmitted.
REQ-040 Write 8'hff to F201 -> the transmitted frame carries all 8 data bits set (bit 7 not masked).
